shift_seq_ctrl: RTL and testbench

- Sequencer for the 4-bit right-shift register datapath used on the lab boards.
- Accepts a parallel word with a valid/ready handshake and shifts it out LSB-first on `ser_out`.
- Simultaneously captures `ser_in` into the same register and presents the captured word with a valid/ready handshake.
- Sits between switch/button logic (or a CPU-style requester) and any serial link or loopback; a programmable divider paces the shifts.

---
 rtl/shift_seq_pkg.sv | 28 ++
 rtl/shift_seq_tick.sv | 43 ++++
 rtl/shift_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift_seq_ctrl serial sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DIV   = 1;
  localparam int unsigned PAR_MAX_W = 64;

  // Bit counter must reach WIDTH+1 when the parity slot is present.
  function automatic int unsigned bit_cnt_w(input int unsigned width);
    return $clog2(width + 32'd2);
  endfunction

  // Divider counter covers 0..DIV-1.
  function automatic int unsigned div_cnt_w(input int unsigned div);
    return $clog2(div + 32'd1);
  endfunction

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/shift_seq_tick.sv
// Shift-slot pacing: counts DIV clocks per slot and flags the slot's shift edge.
module shift_seq_tick
  import shift_seq_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic act_nx,
  output logic tick_c,
  output logic shift_en
);

  localparam int unsigned DIV_W = div_cnt_w(DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nx;

  always_comb begin
    cnt_nx = cnt;
    if (clr || (cnt == LAST)) begin
      cnt_nx = '0;
    end else begin
      cnt_nx = cnt + DIV_W'(1);
    end
  end

  assign tick_c = !clr && (cnt == LAST);

  // shift_en is registered, so it is derived from the counter value of the coming cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      shift_en <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      shift_en <= act_nx && (cnt_nx == LAST);
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Right-shift sequencer: loads a word, shifts it out LSB-first while capturing ser_in.
// Define SHIFT_SEQ_PARITY_EN to append an even-parity slot and report parity_err.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             shift_en,
  output logic             busy,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             parity_err
);

  localparam int unsigned BIT_W = bit_cnt_w(WIDTH);
`ifdef SHIFT_SEQ_PARITY_EN
  localparam int unsigned NSHIFT = WIDTH + 1;
`else
  localparam int unsigned NSHIFT = WIDTH;
`endif

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nx;
  logic [WIDTH-1:0] rx_data_nx;
  logic [BIT_W-1:0] bitcnt;
  logic [BIT_W-1:0] bitcnt_nx;
  logic             start_ready_nx;
  logic             ser_out_nx;
  logic             busy_nx;
  logic             rx_valid_nx;
  logic             tick_c;
`ifdef SHIFT_SEQ_PARITY_EN
  logic             tx_par;
  logic             tx_par_nx;
  logic             rx_par;
  logic             rx_par_nx;
  logic             parity_err_nx;
`endif

  shift_seq_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != SHIFT),
    .act_nx  (state_nx == SHIFT),
    .tick_c  (tick_c),
    .shift_en(shift_en)
  );

  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    bitcnt_nx  = bitcnt;
    rx_data_nx = rx_data;
`ifdef SHIFT_SEQ_PARITY_EN
    tx_par_nx  = tx_par;
    rx_par_nx  = rx_par;
`endif

    unique case (state)
      IDLE: begin
        if (start_valid && start_ready) begin
          state_nx  = SHIFT;
          sreg_nx   = tx_data;
          bitcnt_nx = '0;
`ifdef SHIFT_SEQ_PARITY_EN
          tx_par_nx = even_par(PAR_MAX_W'(tx_data));
`endif
        end
      end
      SHIFT: begin
        if (tick_c) begin
          bitcnt_nx = bitcnt + BIT_W'(1);
          if (bitcnt < BIT_W'(WIDTH)) begin
            sreg_nx    = {ser_in, sreg[WIDTH-1:1]};
            rx_data_nx = sreg_nx;
          end
`ifdef SHIFT_SEQ_PARITY_EN
          else begin
            rx_par_nx = ser_in;
          end
`endif
          if (bitcnt_nx == BIT_W'(NSHIFT)) begin
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (rx_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Registered outputs take the values belonging to the state being entered.
    start_ready_nx = (state_nx == IDLE);
    busy_nx        = (state_nx != IDLE);
    rx_valid_nx    = (state_nx == HOLD);
    ser_out_nx     = 1'b0;
    if (state_nx == SHIFT) begin
`ifdef SHIFT_SEQ_PARITY_EN
      ser_out_nx = (bitcnt_nx < BIT_W'(WIDTH)) ? sreg_nx[0] : tx_par_nx;
`else
      ser_out_nx = sreg_nx[0];
`endif
    end
`ifdef SHIFT_SEQ_PARITY_EN
    parity_err_nx = (state_nx == HOLD) && (rx_par_nx ^ (^sreg_nx));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      bitcnt      <= '0;
      start_ready <= 1'b1;
      ser_out     <= 1'b0;
      busy        <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
`ifdef SHIFT_SEQ_PARITY_EN
      tx_par      <= 1'b0;
      rx_par      <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      sreg        <= sreg_nx;
      bitcnt      <= bitcnt_nx;
      start_ready <= start_ready_nx;
      ser_out     <= ser_out_nx;
      busy        <= busy_nx;
      rx_valid    <= rx_valid_nx;
      rx_data     <= rx_data_nx;
`ifdef SHIFT_SEQ_PARITY_EN
      tx_par      <= tx_par_nx;
      rx_par      <= rx_par_nx;
      parity_err  <= parity_err_nx;
`endif
    end
  end

`ifndef SHIFT_SEQ_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: DIV=1 and DIV=3 instances against a slot-timing reference model.
module tb_shift_seq_ctrl;

  localparam int unsigned W = 4;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned NSLOT = W + PAR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rst;
  logic [1:0]   start_valid;
  logic [1:0]   ser_drv;
  logic [1:0]   loop;
  logic [1:0]   kill;
  logic [1:0]   rx_ready;
  logic [1:0]   start_ready;
  logic [1:0]   ser_out;
  logic [1:0]   shift_en;
  logic [1:0]   busy;
  logic [1:0]   rx_valid;
  logic [1:0]   parity_err;
  logic [1:0]   ser_in;
  logic [W-1:0] tx_data [2];
  logic [W-1:0] rx_data [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int unsigned DIV = (g == 0) ? 1 : 3;

    // Model: a transaction is a handshake plus NSLOT slots of DIV cycles, then HOLD.
    bit           m_busy = 1'b0;
    bit           m_hold = 1'b0;
    bit           m_par  = 1'b0;
    bit           par_q  = 1'b0;
    int unsigned  j      = 0;
    int unsigned  slot;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_rx   = '0;
    logic         exp_so;
    bit           shifting;

    assign ser_in[g] = loop[g] ? (ser_out[g] & ~(kill[g] & par_q)) : ser_drv[g];

    shift_seq_ctrl #(
      .WIDTH(W),
      .DIV  (DIV)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .start_valid(start_valid[g]),
      .start_ready(start_ready[g]),
      .tx_data    (tx_data[g]),
      .ser_in     (ser_in[g]),
      .ser_out    (ser_out[g]),
      .shift_en   (shift_en[g]),
      .busy       (busy[g]),
      .rx_valid   (rx_valid[g]),
      .rx_ready   (rx_ready[g]),
      .rx_data    (rx_data[g]),
      .parity_err (parity_err[g])
    );

    always @(posedge clk or posedge rst[g]) begin
      if (rst[g]) begin
        m_busy = 1'b0;
        m_hold = 1'b0;
        m_par  = 1'b0;
        j      = 0;
        m_word = '0;
        m_rx   = '0;
      end else if (!m_busy) begin
        if (start_valid[g]) begin
          m_busy = 1'b1;
          m_hold = 1'b0;
          j      = 0;
          m_word = tx_data[g];
        end
      end else if (!m_hold) begin
        if (j % DIV == DIV - 1) begin
          slot = j / DIV;
          if (slot < W) m_rx[slot] = ser_in[g];
          else m_par = ser_in[g];
          if (slot == NSLOT - 1) m_hold = 1'b1;
        end
        j++;
      end else if (rx_ready[g]) begin
        m_busy = 1'b0;
        m_hold = 1'b0;
      end
    end

    always @(negedge clk) begin
      shifting = m_busy && !m_hold;
      slot     = j / DIV;
      exp_so   = 1'b0;
      if (shifting) exp_so = (slot < W) ? m_word[slot] : ^m_word;
      check($sformatf("div%0d.start_ready", DIV), start_ready[g], !m_busy);
      check($sformatf("div%0d.busy", DIV), busy[g], m_busy);
      check($sformatf("div%0d.rx_valid", DIV), rx_valid[g], m_hold);
      check($sformatf("div%0d.shift_en", DIV), shift_en[g], shifting && (j % DIV == DIV - 1));
      check($sformatf("div%0d.ser_out", DIV), ser_out[g], exp_so);
      if (!shifting) check($sformatf("div%0d.rx_data", DIV), rx_data[g], m_rx);
      check($sformatf("div%0d.parity_err", DIV), parity_err[g],
            (PAR != 0) && m_hold && (m_par ^ (^m_rx)));
      par_q = shifting && (slot == W);
    end
  end

  task automatic send(input int g, input logic [W-1:0] word);
    int n = 0;
    start_valid[g] = 1'b1;
    tx_data[g]     = word;
    while (!start_ready[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send.accept", start_ready[g], 1);
    @(negedge clk);
    start_valid[g] = 1'b0;
    tx_data[g]     = W'($urandom);
  endtask

  task automatic wait_valid(input int g, output int n);
    n = 0;
    while (!rx_valid[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait.rx_valid", rx_valid[g], 1);
  endtask

  task automatic release_rx(input int g);
    rx_ready[g] = 1'b1;
    @(negedge clk);
    rx_ready[g] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    logic [W-1:0] seq;
    rst         = '1;
    start_valid = '0;
    ser_drv     = '0;
    loop        = '0;
    kill        = '0;
    rx_ready    = '0;
    tx_data[0]  = '0;
    tx_data[1]  = '0;
    repeat (2) @(negedge clk);
    check("rst.start_ready", start_ready, 2'b11);
    check("rst.busy", busy, 2'b00);
    check("rst.rx_valid", rx_valid, 2'b00);
    check("rst.shift_en", shift_en, 2'b00);
    check("rst.ser_out", ser_out, 2'b00);
    check("rst.rx_data", rx_data[0], 0);
    rst = '0;
    @(negedge clk);

    // Loopback, DIV=1
    loop[0] = 1'b1;
    send(0, 4'b1011);
    seq = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      check("t1.ser_out", ser_out[0], seq[i]);
      @(negedge clk);
    end
    wait_valid(0, n);
    check("t1.latency", n + 4, NSLOT);
    check("t1.rx_data", rx_data[0], 4'b1011);

    // Backpressure in HOLD with a competing start request
    start_valid[0] = 1'b1;
    tx_data[0]     = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3.rx_valid", rx_valid[0], 1);
      check("t3.rx_data", rx_data[0], 4'b1011);
      check("t3.start_ready", start_ready[0], 0);
    end
    start_valid[0] = 1'b0;
    release_rx(0);
    check("t3.idle_ready", start_ready[0], 1);
    check("t3.idle_valid", rx_valid[0], 0);
    check("t3.idle_rx_hold", rx_data[0], 4'b1011);

    // Async reset after two shifts, then a clean transaction
    send(0, 4'b1010);
    repeat (2) @(negedge clk);
    #2 rst[0] = 1'b1;
    #1;
    check("t4.start_ready", start_ready[0], 1);
    check("t4.busy", busy[0], 0);
    check("t4.shift_en", shift_en[0], 0);
    check("t4.ser_out", ser_out[0], 0);
    check("t4.rx_valid", rx_valid[0], 0);
    check("t4.rx_data", rx_data[0], 0);
    @(negedge clk);
    rst[0] = 1'b0;
    send(0, 4'b0110);
    wait_valid(0, n);
    check("t4.rx_after", rx_data[0], 4'b0110);
    release_rx(0);

`ifdef SHIFT_SEQ_PARITY_EN
    // Parity slot: clean loopback, then a corrupted parity bit
    send(0, 4'b0111);
    wait_valid(0, n);
    check("t6.par_ok", parity_err[0], 0);
    release_rx(0);
    kill[0] = 1'b1;
    send(0, 4'b0111);
    wait_valid(0, n);
    check("t6.par_bad", parity_err[0], 1);
    release_rx(0);
    kill[0] = 1'b0;
`endif

    // Back-to-back with start_valid and rx_ready held
    loop[0]        = 1'b0;
    rx_ready[0]    = 1'b1;
    start_valid[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      tx_data[0] = W'($urandom);
      ser_drv[0] = 1'($urandom);
    end
    start_valid[0] = 1'b0;
    repeat (NSLOT + 4) @(negedge clk);
    rx_ready[0] = 1'b0;
    check("t5.drained", busy[0], 0);

    // DIV=3, ser_in tied high
    loop[1]    = 1'b0;
    ser_drv[1] = 1'b1;
    send(1, 4'b0000);
    pulses = 0;
    n      = 0;
    while (!rx_valid[1] && n < 200) begin
      pulses += int'(shift_en[1]);
      @(negedge clk);
      n++;
    end
    check("t2.pulses", pulses, NSLOT);
    check("t2.latency", n, NSLOT * 3);
    check("t2.rx_data", rx_data[1], 4'b1111);
    release_rx(1);

    // Randomised traffic on both instances with occasional async resets
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        start_valid[g] = ($urandom_range(3) != 0);
        tx_data[g]     = W'($urandom);
        ser_drv[g]     = 1'($urandom);
        rx_ready[g]    = ($urandom_range(2) == 0);
        loop[g]        = 1'($urandom);
        kill[g]        = 1'($urandom);
      end
      if ($urandom_range(99) == 0) begin
        #2 rst[$urandom_range(1)] = 1'b1;
        #1 rst = '0;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
